// File: rtl/ground_pkg.sv
// ground_pkg
//   Shared types and widths for the ground carry tracker.
//   carry_state_t : rider state machine encoding
//   POS_W         : width of signed screen positions
//   CARRY_W       : width of signed per-frame carry outputs
//   CALC_W        : one guard bit over POS_W so position differences never wrap
//   sat_carry()   : clamp a CALC_W-wide signed value to +/-max_c and narrow to CARRY_W

package ground_pkg;

    localparam int unsigned POS_W   = 11;
    localparam int unsigned CARRY_W = 8;
    localparam int unsigned CALC_W  = POS_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        LANDING,
        RIDING,
        DETACH
    } carry_state_t;

    // max_c must fit in CARRY_W as a positive signed value.
    function automatic logic signed [CARRY_W-1:0] sat_carry(
        input logic signed [CALC_W-1:0] value,
        input int unsigned              max_c
    );
        logic signed [CALC_W-1:0] pos_lim;
        logic signed [CALC_W-1:0] neg_lim;
        logic signed [CALC_W-1:0] clamped;
        pos_lim = $signed(CALC_W'(max_c));
        neg_lim = -pos_lim;
        if (value > pos_lim) begin
            clamped = pos_lim;
        end else if (value < neg_lim) begin
            clamped = neg_lim;
        end else begin
            clamped = value;
        end
        return CARRY_W'(clamped);
    endfunction

endpackage

// File: rtl/frame_delta.sv
// frame_delta
//   Per-axis frame-to-frame displacement of the ground piece. Remembers the
//   position seen at the previous start-of-frame and reports the saturated
//   difference for the current one. The first frame after reset reports 0.
// Ports
//   clk    in   system clock
//   reset  in   asynchronous active-high reset
//   sof    in   start-of-frame pulse; captures pos as the new reference
//   pos    in   current ground position (signed, POS_W)
//   delta  out  saturated pos - prev (signed, CARRY_W), valid on the sof cycle

module frame_delta
    import ground_pkg::*;
#(
    parameter int unsigned MAX_CARRY = 31
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      sof,
    input  logic signed [POS_W-1:0]   pos,
    output logic signed [CARRY_W-1:0] delta
);

    logic signed [POS_W-1:0]  prev_q;
    logic                     prev_valid_q;
    logic signed [CALC_W-1:0] diff;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
        end else if (sof) begin
            prev_q       <= pos;
            prev_valid_q <= 1'b1;
        end
    end

    // Guard bit keeps e.g. +1023 - (-1024) representable before clamping.
    always_comb begin
        diff  = {pos[POS_W-1], pos} - {prev_q[POS_W-1], prev_q};
        delta = '0;
        if (prev_valid_q) begin
            delta = sat_carry(diff, MAX_CARRY);
        end
    end

endmodule

// File: rtl/ground_carry_tracker.sv
// ground_carry_tracker
//   Lets the player ride a moving ground piece. Once per frame it measures how
//   far the ground moved, decides whether the player is standing on it, and
//   when riding emits that movement as a carry delta for the player-move block.
// Ports
//   clk              in   system clock
//   reset            in   asynchronous active-high reset
//   startOfFrame     in   one-cycle pulse per frame
//   groundTopLeftX/Y in   ground position (signed)
//   playerCenterX    in   player horizontal centre (signed)
//   collisionGround  in   feet/ground overlap, any cycle of the frame
//   playerJump       in   jump request, any cycle of the frame
//   carryDX/DY       out  carry for this frame, 0 unless riding
//   carryValid       out  one-cycle pulse the cycle after startOfFrame
//   riding           out  high while in the RIDING state

module ground_carry_tracker
    import ground_pkg::*;
#(
    parameter int unsigned PLAT_WIDTH      = 64,
    parameter int unsigned LAND_FRAMES     = 2,
    parameter int unsigned COOLDOWN_FRAMES = 8,
    parameter int unsigned MAX_CARRY       = 31
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      startOfFrame,
    input  logic signed [POS_W-1:0]   groundTopLeftX,
    input  logic signed [POS_W-1:0]   groundTopLeftY,
    input  logic signed [POS_W-1:0]   playerCenterX,
    input  logic                      collisionGround,
    input  logic                      playerJump,
    output logic signed [CARRY_W-1:0] carryDX,
    output logic signed [CARRY_W-1:0] carryDY,
    output logic                      carryValid,
    output logic                      riding
);

    localparam int unsigned LAND_W = 3;
    localparam int unsigned COOL_W = 4;

    // ------------------------------------------------------------------
    // Per-axis displacement
    // ------------------------------------------------------------------
    logic signed [CARRY_W-1:0] delta_x;
    logic signed [CARRY_W-1:0] delta_y;

    frame_delta #(
        .MAX_CARRY (MAX_CARRY)
    ) u_delta_x (
        .clk   (clk),
        .reset (reset),
        .sof   (startOfFrame),
        .pos   (groundTopLeftX),
        .delta (delta_x)
    );

    frame_delta #(
        .MAX_CARRY (MAX_CARRY)
    ) u_delta_y (
        .clk   (clk),
        .reset (reset),
        .sof   (startOfFrame),
        .pos   (groundTopLeftY),
        .delta (delta_y)
    );

    // ------------------------------------------------------------------
    // Sticky per-frame event flags
    // ------------------------------------------------------------------
    logic col_seen_q;
    logic jump_seen_q;
    logic col_eval;
    logic jump_eval;

    // Include the SOF-cycle inputs so an event on that cycle is not lost.
    always_comb begin
        col_eval  = col_seen_q | collisionGround;
        jump_eval = jump_seen_q | playerJump;
    end

    // ------------------------------------------------------------------
    // Horizontal range check, done one bit wider so groundX + width cannot wrap
    // ------------------------------------------------------------------
    logic signed [CALC_W-1:0] gx_ext;
    logic signed [CALC_W-1:0] gx_end;
    logic signed [CALC_W-1:0] px_ext;
    logic                     on_ground;

    always_comb begin
        gx_ext    = {groundTopLeftX[POS_W-1], groundTopLeftX};
        px_ext    = {playerCenterX[POS_W-1], playerCenterX};
        gx_end    = gx_ext + $signed(CALC_W'(PLAT_WIDTH));
        on_ground = col_eval && (px_ext >= gx_ext) && (px_ext < gx_end);
    end

    // ------------------------------------------------------------------
    // Rider state machine, advances only on startOfFrame
    // ------------------------------------------------------------------
    carry_state_t      state_q;
    carry_state_t      state_d;
    logic [LAND_W-1:0] land_cnt_q;
    logic [LAND_W-1:0] land_cnt_d;
    logic [COOL_W-1:0] cool_cnt_q;
    logic [COOL_W-1:0] cool_cnt_d;

    always_comb begin
        state_d    = state_q;
        land_cnt_d = land_cnt_q;
        cool_cnt_d = cool_cnt_q;
        if (startOfFrame) begin
            unique case (state_q)
                IDLE: begin
                    if (on_ground) begin
                        land_cnt_d = LAND_W'(1);
                        state_d    = (LAND_FRAMES == 1) ? RIDING : LANDING;
                    end
                end
                LANDING: begin
                    // Jump wins over contact seen in the same frame.
                    if (jump_eval) begin
                        state_d    = DETACH;
                        cool_cnt_d = COOL_W'(COOLDOWN_FRAMES);
                    end else if (!on_ground) begin
                        state_d    = IDLE;
                        land_cnt_d = '0;
                    end else begin
                        land_cnt_d = land_cnt_q + LAND_W'(1);
                        if (land_cnt_d == LAND_W'(LAND_FRAMES)) begin
                            state_d = RIDING;
                        end
                    end
                end
                RIDING: begin
                    if (jump_eval) begin
                        state_d    = DETACH;
                        cool_cnt_d = COOL_W'(COOLDOWN_FRAMES);
                    end else if (!on_ground) begin
                        state_d = IDLE;
                    end
                end
                DETACH: begin
                    // Contact is deliberately ignored until the cooldown expires.
                    cool_cnt_d = cool_cnt_q - COOL_W'(1);
                    if (cool_cnt_d == '0) begin
                        state_d    = IDLE;
                        land_cnt_d = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State, flags and registered outputs
    // ------------------------------------------------------------------
    logic signed [CARRY_W-1:0] carry_dx_q;
    logic signed [CARRY_W-1:0] carry_dy_q;
    logic                      carry_valid_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            land_cnt_q    <= '0;
            cool_cnt_q    <= '0;
            col_seen_q    <= 1'b0;
            jump_seen_q   <= 1'b0;
            carry_dx_q    <= '0;
            carry_dy_q    <= '0;
            carry_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            land_cnt_q    <= land_cnt_d;
            cool_cnt_q    <= cool_cnt_d;
            carry_valid_q <= startOfFrame;
            if (startOfFrame) begin
                col_seen_q  <= 1'b0;
                jump_seen_q <= 1'b0;
                // Carry is gated by the state being entered, not the one being left.
                carry_dx_q  <= (state_d == RIDING) ? delta_x : '0;
                carry_dy_q  <= (state_d == RIDING) ? delta_y : '0;
            end else begin
                col_seen_q  <= col_eval;
                jump_seen_q <= jump_eval;
            end
        end
    end

    always_comb begin
        carryDX    = carry_dx_q;
        carryDY    = carry_dy_q;
        carryValid = carry_valid_q;
        riding     = (state_q == RIDING);
    end

endmodule

// File: tb/tb_ground_carry_tracker.sv
// Bench for ground_carry_tracker: directed frames against a frame-level model,
// plus literal expectations at the points of interest.

module tb_ground_carry_tracker;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              startOfFrame = 1'b0;
    logic signed [10:0] groundTopLeftX = '0;
    logic signed [10:0] groundTopLeftY = '0;
    logic signed [10:0] playerCenterX = '0;
    logic              collisionGround = 1'b0;
    logic              playerJump = 1'b0;
    logic signed [7:0] carryDX;
    logic signed [7:0] carryDY;
    logic              carryValid;
    logic              riding;

    ground_carry_tracker dut (
        .clk             (clk),
        .reset           (reset),
        .startOfFrame    (startOfFrame),
        .groundTopLeftX  (groundTopLeftX),
        .groundTopLeftY  (groundTopLeftY),
        .playerCenterX   (playerCenterX),
        .collisionGround (collisionGround),
        .playerJump      (playerJump),
        .carryDX         (carryDX),
        .carryDY         (carryDY),
        .carryValid      (carryValid),
        .riding          (riding)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    localparam int PlatWidth = 64;
    localparam int LandFrames = 2;
    localparam int CoolFrames = 8;
    localparam int MaxCarry = 31;

    // mode: 0 off ground, 1 settling, 2 riding, 3 jumped
    int m_mode = 0;
    int m_contact_frames = 0;
    int m_cool_left = 0;
    bit m_have_prev = 0;
    int m_prev_x = 0;
    int m_prev_y = 0;
    bit m_col = 0;
    bit m_jmp = 0;
    int exp_dx = 0;
    int exp_dy = 0;
    int exp_valid = 0;
    int exp_riding = 0;

    function automatic int clamp(input int v);
        if (v > MaxCarry) return MaxCarry;
        if (v < -MaxCarry) return -MaxCarry;
        return v;
    endfunction

    initial begin
        int gx, gy, px, dx, dy;
        bit col, jmp, on;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_mode = 0; m_contact_frames = 0; m_cool_left = 0;
                m_have_prev = 0; m_prev_x = 0; m_prev_y = 0;
                m_col = 0; m_jmp = 0;
                exp_dx = 0; exp_dy = 0; exp_valid = 0;
            end else if (startOfFrame) begin
                col = m_col || collisionGround;
                jmp = m_jmp || playerJump;
                m_col = 0; m_jmp = 0;
                gx = groundTopLeftX; gy = groundTopLeftY; px = playerCenterX;
                dx = m_have_prev ? clamp(gx - m_prev_x) : 0;
                dy = m_have_prev ? clamp(gy - m_prev_y) : 0;
                m_prev_x = gx; m_prev_y = gy; m_have_prev = 1;
                on = col && (px >= gx) && (px < gx + PlatWidth);
                case (m_mode)
                    0: if (on) begin
                        m_contact_frames = 1;
                        m_mode = (m_contact_frames >= LandFrames) ? 2 : 1;
                    end
                    1: if (jmp) begin
                        m_mode = 3; m_cool_left = CoolFrames;
                    end else if (!on) begin
                        m_mode = 0;
                    end else begin
                        m_contact_frames++;
                        if (m_contact_frames >= LandFrames) m_mode = 2;
                    end
                    2: if (jmp) begin
                        m_mode = 3; m_cool_left = CoolFrames;
                    end else if (!on) begin
                        m_mode = 0;
                    end
                    default: begin
                        m_cool_left--;
                        if (m_cool_left == 0) m_mode = 0;
                    end
                endcase
                exp_valid = 1;
                exp_dx = (m_mode == 2) ? dx : 0;
                exp_dy = (m_mode == 2) ? dy : 0;
            end else begin
                m_col = m_col || collisionGround;
                m_jmp = m_jmp || playerJump;
                exp_valid = 0;
            end
            exp_riding = (m_mode == 2) ? 1 : 0;
        end
    end

    // ---------------- per-cycle compare ----------------
    bit checking = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (checking) begin
                check("model_valid", carryValid, exp_valid);
                check("model_dx", carryDX, exp_dx);
                check("model_dy", carryDY, exp_dy);
                check("model_riding", riding, exp_riding);
            end
        end
    end

    // ---------------- stimulus ----------------
    int cur_gx = 100;
    int cur_gy = 200;
    int cur_px = 130;

    // Non-SOF part of a frame with optional contact and jump pulses.
    task automatic mid(input bit col, input bit jmp);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            collisionGround = (i == 1) ? col : 1'b0;
            playerJump      = (i == 2) ? jmp : 1'b0;
        end
    endtask

    // SOF cycle; returns one cycle later, when the outputs have updated.
    task automatic sof();
        @(posedge clk); #1;
        collisionGround = 1'b0;
        playerJump      = 1'b0;
        startOfFrame    = 1'b1;
        groundTopLeftX  = 11'(cur_gx);
        groundTopLeftY  = 11'(cur_gy);
        playerCenterX   = 11'(cur_px);
        cur_gy++;
        @(posedge clk); #1;
        startOfFrame = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", carryValid, 0);
        check("reset_dx", carryDX, 0);
        check("reset_riding", riding, 0);
        reset = 1'b0;
        checking = 1;

        // 1: steady contact, ground Y +1 per frame
        for (int k = 0; k < 5; k++) begin
            mid(1, 0);
            sof();
            if (k == 0) check("t1_not_yet_riding", riding, 0);
            if (k == 1) begin
                check("t1_riding", riding, 1);
                check("t1_dy", carryDY, 1);
                check("t1_valid", carryValid, 1);
            end
        end
        @(posedge clk); #1;
        check("t1_valid_pulse", carryValid, 0);
        check("t1_dy_hold", carryDY, 1);

        // 2: jump while riding, then cooldown of 8 frames
        mid(1, 1);
        sof();
        check("t2_detach_riding", riding, 0);
        check("t2_detach_dy", carryDY, 0);
        for (int k = 1; k <= 10; k++) begin
            mid(1, 0);
            sof();
            if (k == 9) check("t2_cooldown_then_landing", riding, 0);
            if (k == 10) check("t2_rides_again", riding, 1);
        end

        // 3: player centre exactly at right edge -> off
        cur_px = cur_gx + PlatWidth;
        mid(1, 0);
        sof();
        check("t3_edge_riding", riding, 0);
        check("t3_edge_dy", carryDY, 0);
        cur_px = 130;
        mid(1, 0); sof();
        mid(1, 0); sof();
        check("t3_back_on", riding, 1);

        // 4: large steps saturate
        cur_gx = 300; cur_px = 330;
        mid(1, 0); sof();
        check("t4_sat_pos", carryDX, 31);
        cur_gx = 100; cur_px = 130;
        mid(1, 0); sof();
        check("t4_sat_neg", carryDX, -31);
        check("t4_riding", riding, 1);

        // 5: jump and contact together while landing
        mid(0, 0); sof();
        check("t5_idle", riding, 0);
        mid(1, 0); sof();
        mid(1, 1); sof();
        check("t5_detach_riding", riding, 0);
        mid(1, 0); sof();
        check("t5_contact_ignored", riding, 0);
        for (int k = 0; k < 7; k++) begin
            mid(1, 0); sof();
        end
        mid(1, 0); sof();
        mid(1, 0); sof();
        check("t5_rides_after_cooldown", riding, 1);

        // 6: reset while riding
        cur_gx = 105; cur_px = 135;
        mid(1, 0); sof();
        check("t6_dx_before_reset", carryDX, 5);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("t6_reset_dx", carryDX, 0);
        check("t6_reset_dy", carryDY, 0);
        check("t6_reset_riding", riding, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        cur_gx = 500; cur_px = 530;
        mid(1, 0); sof();
        check("t6_first_valid", carryValid, 1);
        check("t6_first_dx", carryDX, 0);
        cur_gx = 502; cur_px = 532;
        mid(1, 0); sof();
        check("t6_second_dx", carryDX, 2);
        check("t6_second_dy", carryDY, 1);

        repeat (4) @(posedge clk);
        checking = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
